car_motion_ctrl: RTL and testbench
==================================

Name: car_motion_ctrl

Overview:
- Motion controller for the remote-control car's two H-bridge motor channels.
- Accepts motion commands (op + target duty) over a valid/ready handshake.
- Derives the PWM time base from the system clock with an internal programmable prescaler.
- Sequences direction changes safely: ramp down, dead time, new direction, ramp up. Sits between the command decoder and the motor driver pins.

Parameters:
- PRESC_DIV, 195, system clocks per PWM tick (>=1); PWM period = 256 ticks.
- RAMP_STEP, 4, duty increment/decrement applied per PWM period during ramps (1..255).
- DEAD_PERIODS, 2, full PWM periods with both bridges coasting between direction changes (>=1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready at posedge
- cmd_op  in  3  0 STOP, 1 FWD, 2 BACK, 3 LEFT, 4 RIGHT, 5-7 treated as STOP
- cmd_duty  in  8  target duty (0..255)
- estop  in  1  synchronous emergency stop, level-sensitive
- pwm_l  out  1  left motor PWM enable
- pwm_r  out  1  right motor PWM enable
- in1, in2  out  1 each  left bridge direction: fwd=10, back=01, coast=00
- in3, in4  out  1 each  right bridge direction, same encoding
- cur_duty  out  8  duty currently applied
- busy  out  1  high in RAMP, BRAKE, DEAD

Behaviour:
- Reset (async, rst_n=0): all outputs 0, cmd_ready 0, prescaler/PWM counters 0, state IDLE. cmd_ready rises on first clock after release.
- Prescaler: counts 0..PRESC_DIV-1; tick when count==PRESC_DIV-1; next cycle wraps to 0. PRESC_DIV=1 gives a tick every clock.
- PWM counter: 8-bit, increments on tick, wraps 255->0. period_end = tick && pwm_cnt==255.
- pwm_l = pwm_r = registered (pwm_cnt < cur_duty) while the respective bridge is non-coast, else 0. Duty 0 gives constant low; 255 gives 255/256 high.
- cur_duty changes only on period_end (glitch-free). Direction pins change only in IDLE/DEAD exit.
- Direction map: FWD L=fwd R=fwd; BACK L=back R=back; LEFT L=back R=fwd; RIGHT L=fwd R=back.
- cmd_ready = (state==IDLE || state==RUN) && !estop. Commands are never queued beyond the single accept.
- IDLE: duty 0, pins coast.
  - Accept STOP: stay in IDLE.
  - Accept a motion op: latch dir/target; drive pins on the next clock; go to RAMP.
- RAMP: on each period_end, cur_duty moves toward the target by RAMP_STEP, saturating exactly at the target (no overshoot, no 8-bit wrap). Enter RUN on the clock cur_duty==target, including immediately if they are already equal.
- RUN:
  - Accept the same op: latch the new target; go to RAMP (up or down).
  - Accept a different op or STOP: latch it as pending; target=0; go to BRAKE.
- BRAKE: ramps to 0 as in RAMP. When duty==0, pins coast and go to DEAD.
- DEAD: count DEAD_PERIODS period_ends, then:
  - pending STOP: go to IDLE.
  - otherwise: apply pending dir pins, load pending target, go to RAMP.
- estop=1: on the next posedge, cur_duty=0, pwm 0, pins coast, pending discarded, state IDLE. Held estop keeps IDLE and cmd_ready 0. Prescaler/PWM counters keep running.
- Simultaneous estop and cmd handshake: estop wins; the command is not accepted (cmd_ready already 0).
- Reset mid-ramp: everything returns to reset values immediately; no pending state survives.

Test Plan:
- Reset/idle: rst_n low 5 clk, release -> all outputs 0, cmd_ready=1 next clk, pins 0000, busy 0.
- Ramp up: PRESC_DIV=1, RAMP_STEP=64, cmd FWD duty 200 -> in1..4=1010 next clk; cur_duty 64,128,192,200 at successive period_ends (256 clk apart); RUN, busy 0; pwm_l high 200 of 256 clk.
- Reverse: from RUN FWD 200, cmd BACK duty 100 -> BRAKE 200->136->72->8->0; pins 0000; DEAD 2 periods (512 clk); pins 0101; ramp 64,100; RUN.
- Turn/stop: from IDLE cmd LEFT 255 -> pins 0110, cur_duty saturates at 255, pwm high 255/256 clk. Cmd STOP -> ramp to 0, DEAD, IDLE, pins 0000.
- Estop mid-ramp: during RAMP at duty 128 assert estop 1 clk -> next clk cur_duty 0, pwm 0, pins 0000, IDLE; cmd_valid during estop not accepted.
- Prescaler: PRESC_DIV=3, duty 1 -> pwm high for exactly 3 clk per 768-clk period; opcode 6 from IDLE behaves as STOP (no pin change).

Source files
------------

// File: rtl/car_motion_ctrl.sv
// car_motion_ctrl: dual H-bridge motion controller. A command (op, duty)
// arrives on cmd_valid/cmd_ready. Duty ramps once per PWM period.
// Reversals brake to zero and coast for a dead time before the new
// direction is applied. estop drops straight to IDLE.
// Outputs: pwm_l/pwm_r, in1..in4, cur_duty, busy.
module car_motion_ctrl #(
  parameter int PRESC_DIV    = 195,
  parameter int RAMP_STEP    = 4,
  parameter int DEAD_PERIODS = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [7:0] cmd_duty,
  input  logic       estop,
  output logic       pwm_l,
  output logic       pwm_r,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  output logic       in4,
  output logic [7:0] cur_duty,
  output logic       busy
);
  localparam int PW =
    (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
  localparam int DW =
    (DEAD_PERIODS > 1) ? $clog2(DEAD_PERIODS) : 1;

  localparam logic [2:0] OP_STOP  = 3'd0;
  localparam logic [2:0] OP_FWD   = 3'd1;
  localparam logic [2:0] OP_BACK  = 3'd2;
  localparam logic [2:0] OP_LEFT  = 3'd3;
  localparam logic [2:0] OP_RIGHT = 3'd4;

  localparam logic [8:0] STEP9 = 9'(RAMP_STEP);
  localparam logic [7:0] STEP8 = 8'(RAMP_STEP);

  typedef enum logic [2:0] {
    S_IDLE, S_RAMP, S_RUN, S_BRAKE, S_DEAD
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    pwm_cnt_q, pwm_cnt_d;
  logic [7:0]    duty_q, duty_d;
  logic [7:0]    tgt_q, tgt_d;
  logic [7:0]    pend_duty_q, pend_duty_d;
  logic [2:0]    op_q, op_d;
  logic [2:0]    pend_op_q, pend_op_d;
  logic [DW-1:0] dead_q, dead_d;
  logic [3:0]    pins_q, pins_d;
  logic          pwm_l_q, pwm_l_d;
  logic          pwm_r_q, pwm_r_d;
  logic          rdy_en_q, rdy_en_d;

  logic       tick;
  logic       period_end;
  logic       accept;
  logic [2:0] op_n;
  logic [7:0] duty_step;

  // {in1,in2,in3,in4}; 10 = fwd, 01 = back
  function automatic logic [3:0] dir_pins(
    input logic [2:0] op
  );
    unique case (op)
      OP_FWD:   dir_pins = 4'b1010;
      OP_BACK:  dir_pins = 4'b0101;
      OP_LEFT:  dir_pins = 4'b0110;
      OP_RIGHT: dir_pins = 4'b1001;
      default:  dir_pins = 4'b0000;
    endcase
  endfunction

  assign tick = presc_q == PW'(PRESC_DIV - 1);
  assign period_end = tick && (pwm_cnt_q == 8'hFF);
  assign cmd_ready = rdy_en_q && !estop &&
    (state_q == S_IDLE || state_q == S_RUN);
  assign accept = cmd_valid && cmd_ready;
  assign op_n = (cmd_op > OP_RIGHT) ? OP_STOP : cmd_op;

  // One ramp step toward the target, clamped so it never overshoots.
  always_comb begin
    duty_step = duty_q;
    if (duty_q < tgt_q) begin
      if ({1'b0, tgt_q} - {1'b0, duty_q} <= STEP9)
        duty_step = tgt_q;
      else
        duty_step = duty_q + STEP8;
    end else if (duty_q > tgt_q) begin
      if ({1'b0, duty_q} - {1'b0, tgt_q} <= STEP9)
        duty_step = tgt_q;
      else
        duty_step = duty_q - STEP8;
    end
  end

  always_comb begin
    state_d     = state_q;
    presc_d     = tick ? '0 : presc_q + 1'b1;
    pwm_cnt_d   = pwm_cnt_q + {7'd0, tick};
    duty_d      = duty_q;
    tgt_d       = tgt_q;
    pend_duty_d = pend_duty_q;
    op_d        = op_q;
    pend_op_d   = pend_op_q;
    dead_d      = dead_q;
    pins_d      = pins_q;
    rdy_en_d    = 1'b1;
    pwm_l_d     = (pins_q[3:2] != 2'b00) &&
                  (pwm_cnt_q < duty_q);
    pwm_r_d     = (pins_q[1:0] != 2'b00) &&
                  (pwm_cnt_q < duty_q);
    if (estop) begin
      state_d     = S_IDLE;
      duty_d      = '0;
      tgt_d       = '0;
      pend_duty_d = '0;
      op_d        = OP_STOP;
      pend_op_d   = OP_STOP;
      dead_d      = '0;
      pins_d      = '0;
      pwm_l_d     = 1'b0;
      pwm_r_d     = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept && op_n != OP_STOP) begin
            op_d    = op_n;
            tgt_d   = cmd_duty;
            pins_d  = dir_pins(op_n);
            state_d = S_RAMP;
          end
        end
        S_RAMP: begin
          if (duty_q == tgt_q)
            state_d = S_RUN;
          else if (period_end)
            duty_d = duty_step;
        end
        S_RUN: begin
          if (accept) begin
            if (op_n == op_q) begin
              tgt_d   = cmd_duty;
              state_d = S_RAMP;
            end else begin
              pend_op_d   = op_n;
              pend_duty_d = cmd_duty;
              tgt_d       = '0;
              state_d     = S_BRAKE;
            end
          end
        end
        S_BRAKE: begin
          if (duty_q == 8'd0) begin
            pins_d  = '0;
            dead_d  = '0;
            state_d = S_DEAD;
          end else if (period_end) begin
            duty_d = duty_step;
          end
        end
        S_DEAD: begin
          if (period_end) begin
            if (dead_q == DW'(DEAD_PERIODS - 1)) begin
              if (pend_op_q == OP_STOP) begin
                op_d    = OP_STOP;
                state_d = S_IDLE;
              end else begin
                op_d    = pend_op_q;
                tgt_d   = pend_duty_q;
                pins_d  = dir_pins(pend_op_q);
                state_d = S_RAMP;
              end
            end else begin
              dead_d = dead_q + 1'b1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      presc_q     <= '0;
      pwm_cnt_q   <= '0;
      duty_q      <= '0;
      tgt_q       <= '0;
      pend_duty_q <= '0;
      op_q        <= OP_STOP;
      pend_op_q   <= OP_STOP;
      dead_q      <= '0;
      pins_q      <= '0;
      pwm_l_q     <= 1'b0;
      pwm_r_q     <= 1'b0;
      rdy_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      pwm_cnt_q   <= pwm_cnt_d;
      duty_q      <= duty_d;
      tgt_q       <= tgt_d;
      pend_duty_q <= pend_duty_d;
      op_q        <= op_d;
      pend_op_q   <= pend_op_d;
      dead_q      <= dead_d;
      pins_q      <= pins_d;
      pwm_l_q     <= pwm_l_d;
      pwm_r_q     <= pwm_r_d;
      rdy_en_q    <= rdy_en_d;
    end
  end

  assign {in1, in2, in3, in4} = pins_q;
  assign pwm_l    = pwm_l_q;
  assign pwm_r    = pwm_r_q;
  assign cur_duty = duty_q;
  assign busy = (state_q == S_RAMP) ||
                (state_q == S_BRAKE) ||
                (state_q == S_DEAD);
endmodule

// File: tb/tb_car_motion_ctrl.sv
// tb_car_motion_ctrl: vector table, hand sequences and random
// transactions against a transaction-level motion model.
module tb_car_motion_ctrl;
  localparam int STEP = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       cmd_valid;
  logic [2:0] cmd_op;
  logic [7:0] cmd_duty;
  logic       estop;
  logic       cmd_ready, pwm_l, pwm_r, busy;
  logic       in1, in2, in3, in4;
  logic [7:0] cur_duty;

  logic       c3_valid;
  logic [2:0] c3_op;
  logic [7:0] c3_duty;
  logic       c3_ready, c3_pl, c3_pr, c3_busy;
  logic       c3_i1, c3_i2, c3_i3, c3_i4;
  logic [7:0] c3_cur;

  car_motion_ctrl #(
    .PRESC_DIV(1), .RAMP_STEP(STEP), .DEAD_PERIODS(2)
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_duty(cmd_duty),
    .estop(estop), .pwm_l(pwm_l), .pwm_r(pwm_r),
    .in1(in1), .in2(in2), .in3(in3), .in4(in4),
    .cur_duty(cur_duty), .busy(busy)
  );

  car_motion_ctrl #(
    .PRESC_DIV(3), .RAMP_STEP(STEP), .DEAD_PERIODS(2)
  ) u_p3 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(c3_valid), .cmd_ready(c3_ready),
    .cmd_op(c3_op), .cmd_duty(c3_duty),
    .estop(1'b0), .pwm_l(c3_pl), .pwm_r(c3_pr),
    .in1(c3_i1), .in2(c3_i2), .in3(c3_i3), .in4(c3_i4),
    .cur_duty(c3_cur), .busy(c3_busy)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name,
                     input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d",
                  name, act, exp);
  endtask

  function automatic int pins();
    return int'({in1, in2, in3, in4});
  endfunction

  // Duty trace: every change of cur_duty with its cycle stamp.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int dq[$];
  int tq[$];
  logic [7:0] last_duty = 8'd0;
  always @(negedge clk) begin
    if (cur_duty != last_duty) begin
      dq.push_back(int'(cur_duty));
      tq.push_back(cyc);
    end
    last_duty = cur_duty;
  end

  // Model: expected duty steps and the cycle gap before each step.
  int eq[$];
  int eg[$];
  logic [3:0] pin_map [8];
  int m_op = 0;
  int m_duty = 0;

  task automatic model_ramp(input int from, input int to,
                            input int gap);
    int v;
    int g;
    v = from;
    g = (eq.size() == 0) ? 0 : gap;
    while (v != to) begin
      if (to > v) v = (to - v <= STEP) ? to : v + STEP;
      else v = (v - to <= STEP) ? to : v - STEP;
      eq.push_back(v);
      eg.push_back(g);
      g = 256;
    end
  endtask

  task automatic cmp_trace(input string tag);
    chk({tag, " steps"}, dq.size(), eq.size());
    for (int i = 0; i < eq.size() && i < dq.size(); i++) begin
      chk({tag, " step duty"}, dq[i], eq[i]);
      if (eg[i] != 0)
        chk({tag, " step gap"}, tq[i] - tq[i-1], eg[i]);
    end
  endtask

  task automatic send(input logic [2:0] op,
                      input logic [7:0] d);
    int n;
    n = 0;
    dq.delete(); tq.delete();
    eq.delete(); eg.delete();
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_duty = d;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("cmd accepted", int'(cmd_ready), 1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic settle(input string tag);
    int n;
    n = 0;
    while (busy && n < 6000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " settle"}, int'(busy), 0);
  endtask

  task automatic pwm_count(input int n,
                           output int cl, output int cr);
    cl = 0;
    cr = 0;
    repeat (n) begin
      @(negedge clk);
      cl += int'(pwm_l);
      cr += int'(pwm_r);
    end
  endtask

  task automatic do_txn(input int op, input int d);
    int nop;
    int cl, cr;
    nop = (op > 4) ? 0 : op;
    send(3'(op), 8'(d));
    if (m_op == 0) begin
      if (nop != 0) begin
        model_ramp(0, d, 0);
        m_op = nop;
        m_duty = d;
      end
    end else if (nop == m_op) begin
      model_ramp(m_duty, d, 0);
      m_duty = d;
    end else begin
      model_ramp(m_duty, 0, 0);
      if (nop != 0) model_ramp(0, d, 768);
      m_op = nop;
      m_duty = (nop != 0) ? d : 0;
    end
    settle("txn");
    cmp_trace("txn");
    chk("txn pins", pins(), int'(pin_map[m_op]));
    chk("txn duty", int'(cur_duty), m_duty);
    pwm_count(256, cl, cr);
    chk("txn pwm_l", cl, m_duty);
    chk("txn pwm_r", cr, m_duty);
  endtask

  typedef struct {
    logic [2:0] op;
    logic [7:0] duty;
    logic [3:0] pins;
    int         duty_exp;
    int         pwm_exp;
  } vec_t;
  vec_t vecs [6];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n, cl, cr, t0;
    int rev_d [6];
    int rev_g [6];
    int up_d [4];

    pin_map = '{4'b0000, 4'b1010, 4'b0101, 4'b0110,
                4'b1001, 4'b0000, 4'b0000, 4'b0000};
    vecs[0] = '{3'd6, 8'd90,  4'b0000, 0,   0};
    vecs[1] = '{3'd1, 8'd0,   4'b1010, 0,   0};
    vecs[2] = '{3'd3, 8'd255, 4'b0110, 255, 255};
    vecs[3] = '{3'd4, 8'd1,   4'b1001, 1,   1};
    vecs[4] = '{3'd2, 8'd64,  4'b0101, 64,  64};
    vecs[5] = '{3'd0, 8'd200, 4'b0000, 0,   0};
    up_d  = '{64, 128, 192, 200};
    rev_d = '{136, 72, 8, 0, 64, 100};
    rev_g = '{0, 256, 256, 256, 768, 256};

    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = 3'd0;
    cmd_duty = 8'd0;
    estop = 1'b0;
    c3_valid = 1'b0;
    c3_op = 3'd0;
    c3_duty = 8'd0;

    // Reset and idle
    repeat (5) @(negedge clk);
    chk("rst cur_duty", int'(cur_duty), 0);
    chk("rst pins", pins(), 0);
    chk("rst pwm", int'({pwm_l, pwm_r}), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst ready", int'(cmd_ready), 0);
    rst_n = 1'b1;
    chk("ready before clk", int'(cmd_ready), 0);
    @(negedge clk);
    chk("ready after clk", int'(cmd_ready), 1);

    // Vector table, each entry from IDLE then back to IDLE
    for (int i = 0; i < 6; i++) begin
      send(vecs[i].op, vecs[i].duty);
      settle("vec");
      chk("vec pins", pins(), int'(vecs[i].pins));
      chk("vec duty", int'(cur_duty), vecs[i].duty_exp);
      pwm_count(256, cl, cr);
      chk("vec pwm_l", cl, vecs[i].pwm_exp);
      chk("vec pwm_r", cr, vecs[i].pwm_exp);
      send(3'd0, 8'd0);
      settle("vec stop");
      chk("vec stop pins", pins(), 0);
      chk("vec stop duty", int'(cur_duty), 0);
    end

    // Ramp up FWD 200 then reverse to BACK 100
    send(3'd1, 8'd200);
    chk("fwd pins next clk", pins(), 4'b1010);
    settle("fwd");
    chk("fwd steps", dq.size(), 4);
    for (int i = 0; i < 4 && i < dq.size(); i++)
      chk("fwd step", dq[i], up_d[i]);
    pwm_count(256, cl, cr);
    chk("fwd pwm_l 200", cl, 200);
    send(3'd2, 8'd100);
    n = 0;
    while (cur_duty != 8'd0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("brake reached 0", int'(cur_duty), 0);
    t0 = cyc;
    repeat (2) @(negedge clk);
    chk("dead pins", pins(), 0);
    chk("dead busy", int'(busy), 1);
    n = 0;
    while (pins() == 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("dead time", cyc - t0, 512);
    chk("back pins", pins(), 4'b0101);
    settle("rev");
    chk("rev steps", dq.size(), 6);
    for (int i = 0; i < 6 && i < dq.size(); i++) begin
      chk("rev step", dq[i], rev_d[i]);
      if (rev_g[i] != 0)
        chk("rev gap", tq[i] - tq[i-1], rev_g[i]);
    end
    m_op = 2;
    m_duty = 100;

    // Random transactions against the model
    for (int k = 0; k < 8; k++)
      do_txn(int'($urandom_range(0, 7)),
             int'($urandom_range(0, 255)));
    do_txn(0, 0);

    // Emergency stop mid-ramp
    send(3'd1, 8'd255);
    n = 0;
    while (cur_duty != 8'd128 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("estop at 128", int'(cur_duty), 128);
    estop = 1'b1;
    cmd_valid = 1'b1;
    cmd_op = 3'd2;
    cmd_duty = 8'd50;
    chk("estop ready", int'(cmd_ready), 0);
    @(negedge clk);
    chk("estop duty", int'(cur_duty), 0);
    chk("estop pins", pins(), 0);
    chk("estop pwm", int'({pwm_l, pwm_r}), 0);
    chk("estop busy", int'(busy), 0);
    chk("estop ready held", int'(cmd_ready), 0);
    estop = 1'b0;
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("estop no accept", pins(), 0);
    chk("estop idle busy", int'(busy), 0);
    chk("estop ready back", int'(cmd_ready), 1);
    m_op = 0;
    m_duty = 0;
    do_txn(4, 150);

    // Prescaler of 3: duty 1 is 3 clocks high per 768
    @(negedge clk);
    c3_valid = 1'b1;
    c3_op = 3'd1;
    c3_duty = 8'd1;
    chk("p3 ready", int'(c3_ready), 1);
    @(negedge clk);
    c3_valid = 1'b0;
    n = 0;
    while (c3_busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("p3 settle", int'(c3_busy), 0);
    chk("p3 duty", int'(c3_cur), 1);
    chk("p3 pins", int'({c3_i1, c3_i2, c3_i3, c3_i4}),
        4'b1010);
    cl = 0;
    repeat (768) begin
      @(negedge clk);
      cl += int'(c3_pl);
    end
    chk("p3 high clks", cl, 3);
    n = 0;
    while (!c3_pl && n < 1000) begin
      @(negedge clk);
      n++;
    end
    t0 = cyc;
    @(negedge clk);
    n = 0;
    while (!c3_pl && n < 1000) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (c3_pl && n < 10) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (!c3_pl && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("p3 period", cyc - t0, 768);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
